ofmap_writer: RTL and testbench

Downstream stage of the convolution chip; it consumes each output vector the CCM produces (`sum` qualified by `sum_reg_valid`). Each vector is FILTER_NUM×PEA_NUM signed bytes. The block applies ReLU, holds up to two vectors in a ping-pong buffer, and serializes them into OUT_W-bit words on a valid/ready stream toward the DRAM write path. It counts vectors per layer, raises `done` at layer end, and flags any vector lost to back-pressure.

---
 rtl/ofmap_pkg.sv | 22 ++
 rtl/ofmap_writer_if.sv | 22 ++
 rtl/ofmap_pingpong.sv | 88 ++++++++
 rtl/ofmap_writer.sv | 107 ++++++++++
 tb/tb_ofmap_writer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ofmap_pkg.sv
// rtl/ofmap_pkg.sv - shared sizing, state encoding and ReLU helper for the ofmap writer
`timescale 1ns/1ps
package ofmap_pkg;
    localparam int FILTER_NUM = 32;
    localparam int PEA_NUM    = 4;
    localparam int OUT_W      = 32;
    localparam int NUM_VEC    = 256;
    localparam int VEC_W      = FILTER_NUM * PEA_NUM * 8;
    localparam int WPV        = VEC_W / OUT_W;
    localparam int IDX_W      = (WPV > 1) ? $clog2(WPV) : 1;
    localparam int VCNT_W     = $clog2(NUM_VEC + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [7:0] relu8(input logic [7:0] b);
        return b[7] ? 8'h00 : b;
    endfunction
endpackage

// File: rtl/ofmap_writer_if.sv
// rtl/ofmap_writer_if.sv - vector input and word output streams of the ofmap writer
`timescale 1ns/1ps
interface ofmap_writer_if #(
    parameter int VW = ofmap_pkg::VEC_W,
    parameter int OW = ofmap_pkg::OUT_W
);
    logic          sum_valid;
    logic [VW-1:0] sum;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;

    modport master (
        input  sum_valid, sum, out_ready,
        output out_valid, out_data
    );

    modport slave (
        output sum_valid, sum, out_ready,
        input  out_valid, out_data
    );
endinterface

// File: rtl/ofmap_pingpong.sv
// rtl/ofmap_pingpong.sv - two-entry vector buffer serialised into registered output words
`timescale 1ns/1ps
module ofmap_pingpong
    import ofmap_pkg::*;
#(
    parameter int VW = VEC_W,
    parameter int OW = OUT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          wr_en_i,
    input  logic [VW-1:0] wr_data_i,
    input  logic          rd_ready_i,
    output logic          wr_accept_o,
    output logic          rd_valid_o,
    output logic [OW-1:0] rd_data_o,
    output logic          empty_next_o
);
    localparam int NW = VW / OW;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

    logic [VW-1:0] buf_q [2];
    logic [1:0]    occ_q, occ_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic [OW-1:0] data_q, data_d;
    logic          hs, last_hs, accept;
    logic [VW-1:0] head_src;

    always_comb begin
        hs       = valid_q & rd_ready_i;
        last_hs  = hs & (idx_q == LAST_IDX);
        // A full buffer pair still takes a vector when the head frees this cycle.
        accept   = wr_en_i & ((occ_q != 2'd2) | last_hs);
        occ_d    = occ_q + 2'(accept) - 2'(last_hs);
        rd_ptr_d = rd_ptr_q ^ last_hs;
        wr_ptr_d = wr_ptr_q ^ accept;
        idx_d    = idx_q;
        if (last_hs) begin
            idx_d = '0;
        end else if (hs) begin
            idx_d = idx_q + IW'(1);
        end
        // Next head may be the vector being written now; forward it so there is no bubble.
        head_src = (accept && (wr_ptr_q == rd_ptr_d)) ? wr_data_i : buf_q[rd_ptr_d];
        valid_d  = (occ_d != 2'd0);
        data_d   = valid_d ? head_src[idx_d*OW +: OW] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            occ_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else if (clear_i) begin
            occ_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            if (accept) begin
                buf_q[wr_ptr_q] <= wr_data_i;
            end
            occ_q    <= occ_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign wr_accept_o  = accept;
    assign rd_valid_o   = valid_q;
    assign rd_data_o    = data_q;
    assign empty_next_o = (occ_d == 2'd0);
endmodule

// File: rtl/ofmap_writer.sv
// rtl/ofmap_writer.sv - ReLU, layer FSM and overflow tracking around the ping-pong serialiser
`timescale 1ns/1ps
module ofmap_writer
    import ofmap_pkg::*;
#(
    parameter int FILTER_NUM = ofmap_pkg::FILTER_NUM,
    parameter int PEA_NUM    = ofmap_pkg::PEA_NUM,
    parameter int OUT_W      = ofmap_pkg::OUT_W,
    parameter int NUM_VEC    = ofmap_pkg::NUM_VEC
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    ofmap_writer_if.master bus,
    output logic           busy_o,
    output logic           done_o,
    output logic           overflow_o
);
    localparam int VW = FILTER_NUM * PEA_NUM * 8;
    localparam int CW = $clog2(NUM_VEC + 1);
    localparam logic [CW-1:0] VEC_END = CW'(NUM_VEC);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic [VW-1:0] relu_vec;
    logic          wr_en, clear, accept, empty_next;
    logic          pp_valid;
    logic [OUT_W-1:0] pp_data;

    always_comb begin
        for (int i = 0; i < VW / 8; i++) begin
            relu_vec[8*i +: 8] = relu8(bus.sum[8*i +: 8]);
        end
    end

    // Vectors past the layer length are ignored while the last ones drain.
    assign wr_en = (state_q == S_RUN) & bus.sum_valid & (vcnt_q != VEC_END);
    assign clear = (state_q == S_IDLE) & start_i;

    ofmap_pingpong #(.VW(VW), .OW(OUT_W)) u_pingpong (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear),
        .wr_en_i      (wr_en),
        .wr_data_i    (relu_vec),
        .rd_ready_i   (bus.out_ready),
        .wr_accept_o  (accept),
        .rd_valid_o   (pp_valid),
        .rd_data_o    (pp_data),
        .empty_next_o (empty_next)
    );

    always_comb begin
        state_d = state_q;
        vcnt_d  = vcnt_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    vcnt_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (wr_en) begin
                    vcnt_d = vcnt_q + CW'(1);
                    if (!accept) begin
                        ovf_d = 1'b1;
                    end
                end
                if ((vcnt_q == VEC_END) && empty_next) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vcnt_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vcnt_q  <= vcnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.out_valid = pp_valid;
    assign bus.out_data  = pp_data;
    assign busy_o        = (state_q == S_RUN);
    assign done_o        = done_q;
    assign overflow_o    = ovf_q;
endmodule

// File: tb/tb_ofmap_writer.sv
// tb/tb_ofmap_writer.sv - directed bench for ofmap_writer (default layer and a two-vector layer)
`timescale 1ns/1ps
module tb_ofmap_writer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst2_n, start1, start2;
    logic busy1, done1, ovf1, busy2, done2, ovf2;
    int total = 0;
    int bad   = 0;

    ofmap_writer_if #(.VW(1024), .OW(32)) if1 ();
    ofmap_writer_if #(.VW(1024), .OW(32)) if2 ();

    ofmap_writer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .bus(if1),
        .busy_o(busy1), .done_o(done1), .overflow_o(ovf1)
    );

    ofmap_writer #(.NUM_VEC(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .start_i(start2), .bus(if2),
        .busy_o(busy2), .done_o(done2), .overflow_o(ovf2)
    );

    logic [31:0] got1[$];
    logic [31:0] got2[$];
    logic        stall1 = 1'b0;
    logic [31:0] hold1  = '0;
    logic [1023:0] vA, vB, vC, vD, vE, vF;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (stall1 && if1.out_valid) chk("stall_hold", if1.out_data, hold1);
        if (if1.out_valid && if1.out_ready) got1.push_back(if1.out_data);
        if (if2.out_valid && if2.out_ready) got2.push_back(if2.out_data);
        stall1 = if1.out_valid && !if1.out_ready;
        hold1  = if1.out_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mword(input logic [1023:0] v, input int k);
        logic [31:0] w;
        logic [7:0]  x;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            x = v[8*(4*k+b) +: 8];
            w[8*b +: 8] = x[7] ? 8'h00 : x;
        end
        return w;
    endfunction

    function automatic logic [31:0] qget1(input int i);
        return (i < got1.size()) ? got1[i] : 32'hDEADBEEF;
    endfunction

    task automatic chk_vec(input string tag, input int base, input logic [1023:0] v);
        int nerr;
        nerr = 0;
        for (int k = 0; k < 32; k++) begin
            if (qget1(base + k) !== mword(v, k)) nerr++;
        end
        chk(tag, nerr, 0);
    endtask

    task automatic wait_words1(input string tag, input int n);
        for (int i = 0; i < 600 && got1.size() < n; i++) step();
        chk(tag, got1.size(), n);
    endtask

    initial begin
        int ndone, prev_sz, sz_at_done, prev_at_done, busy_at_done, nz;
        for (int i = 0; i < 128; i++) begin
            vA[8*i +: 8] = 8'(i);
            vB[8*i +: 8] = (i == 5) ? 8'h7F : 8'h80;
            vC[8*i +: 8] = 8'(i * 37 + 5);
            vD[8*i +: 8] = 8'(i) ^ 8'h5A;
            vE[8*i +: 8] = 8'(255 - i);
            vF[8*i +: 8] = 8'(i * 7);
        end
        rst_n = 1'b0; rst2_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
        if1.sum_valid = 1'b0; if1.sum = '0; if1.out_ready = 1'b0;
        if2.sum_valid = 1'b0; if2.sum = '0; if2.out_ready = 1'b0;
        repeat (3) step();
        chk("rst_valid", if1.out_valid, 0);
        chk("rst_data", if1.out_data, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_ovf", ovf1, 0);
        chk("rst2_valid", if2.out_valid, 0);
        rst_n = 1'b1; rst2_n = 1'b1;
        step();
        start1 = 1'b1; step(); start1 = 1'b0;
        chk("busy_after_start", busy1, 1);

        // ascending vector, capture latency
        if1.out_ready = 1'b1; if1.sum = vA; if1.sum_valid = 1'b1;
        @(negedge clk);
        chk("A_pre_valid", if1.out_valid, 0);
        step(); if1.sum_valid = 1'b0;
        chk("A_lat_valid", if1.out_valid, 1);
        chk("A_lat_w0", if1.out_data, 32'h03020100);
        wait_words1("A_count", 32);
        chk("A_w0", qget1(0), 32'h03020100);
        chk("A_w31", qget1(31), 32'h7F7E7D7C);
        chk_vec("A_all", 0, vA);
        repeat (3) step();
        chk("A_idle_valid", if1.out_valid, 0);

        // ReLU
        got1.delete();
        if1.sum = vB; if1.sum_valid = 1'b1; step(); if1.sum_valid = 1'b0;
        wait_words1("B_count", 32);
        chk("B_w1", qget1(1), 32'h00007F00);
        nz = 0;
        for (int k = 0; k < 32; k++) if (k != 1 && qget1(k) != 32'h0) nz++;
        chk("B_others_zero", nz, 0);

        // back-pressure
        got1.delete();
        if1.out_ready = 1'b0;
        if1.sum = vC; if1.sum_valid = 1'b1; step(); if1.sum_valid = 1'b0;
        for (int i = 0; i < 200 && got1.size() < 32; i++) begin
            if1.out_ready = ~if1.out_ready;
            step();
        end
        if1.out_ready = 1'b1;
        repeat (4) step();
        chk("C_count", got1.size(), 32);
        chk_vec("C_all", 0, vC);

        // free and fill on the head's last word
        got1.delete();
        if1.out_ready = 1'b0;
        if1.sum = vD; if1.sum_valid = 1'b1; step();
        if1.sum = vE; step(); if1.sum_valid = 1'b0;
        step();
        if1.out_ready = 1'b1;
        repeat (31) step();
        chk("FF_pre_count", got1.size(), 31);
        if1.sum = vF; if1.sum_valid = 1'b1; step(); if1.sum_valid = 1'b0;
        chk("FF_ovf", ovf1, 0);
        wait_words1("FF_count", 96);
        chk_vec("FF_D", 0, vD);
        chk_vec("FF_E", 32, vE);
        chk_vec("FF_F", 64, vF);
        chk("FF_ovf_end", ovf1, 0);

        // overflow
        got1.delete();
        if1.out_ready = 1'b0;
        if1.sum = vA; if1.sum_valid = 1'b1; step();
        if1.sum = vB; step();
        chk("OV_before", ovf1, 0);
        if1.sum = vC; step(); if1.sum_valid = 1'b0;
        chk("OV_set", ovf1, 1);
        repeat (3) step();
        if1.out_ready = 1'b1;
        wait_words1("OV_count", 64);
        repeat (10) step();
        chk("OV_no_extra", got1.size(), 64);
        chk_vec("OV_v0", 0, vA);
        chk_vec("OV_v1", 32, vB);
        chk("OV_sticky", ovf1, 1);

        // two-vector layer: done timing
        start2 = 1'b1; step(); start2 = 1'b0;
        chk("L2_busy", busy2, 1);
        if2.out_ready = 1'b1;
        if2.sum = vA; if2.sum_valid = 1'b1; step();
        if2.sum = vB; step(); if2.sum_valid = 1'b0;
        ndone = 0; sz_at_done = -1; prev_at_done = -1; busy_at_done = -1;
        prev_sz = got2.size();
        for (int i = 0; i < 150; i++) begin
            step();
            if (done2) begin
                if (ndone == 0) begin
                    sz_at_done   = got2.size();
                    prev_at_done = prev_sz;
                    busy_at_done = int'(busy2);
                end
                ndone++;
            end
            prev_sz = got2.size();
        end
        chk("L2_done_pulses", ndone, 1);
        chk("L2_done_words", sz_at_done, 64);
        chk("L2_done_prev_words", prev_at_done, 63);
        chk("L2_done_busy", busy_at_done, 0);
        chk("L2_busy_end", busy2, 0);
        if2.sum = vC; if2.sum_valid = 1'b1; step(); if2.sum_valid = 1'b0;
        repeat (5) step();
        chk("L2_ignore_valid", if2.out_valid, 0);
        chk("L2_ignore_count", got2.size(), 64);

        // asynchronous reset mid-drain
        start2 = 1'b1; step(); start2 = 1'b0;
        if2.out_ready = 1'b1;
        if2.sum = vE; if2.sum_valid = 1'b1; step(); if2.sum_valid = 1'b0;
        repeat (4) step();
        chk("RST_pre_valid", if2.out_valid, 1);
        #2 rst2_n = 1'b0;
        #1;
        chk("RST_valid", if2.out_valid, 0);
        chk("RST_data", if2.out_data, 0);
        chk("RST_busy", busy2, 0);
        chk("RST_ovf", ovf2, 0);
        step();
        rst2_n = 1'b1;
        step();
        chk("RST_stay_idle", if2.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
